// File: rtl/emu_osc_pkg.sv
// Shared types and helpers for the emulated-clock oscillator.
package emu_osc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } osc_state_e;

    localparam int DT_WIDTH_DEF  = 32;
    localparam int CNT_WIDTH_DEF = 16;

    // A zero-length phase would request dt=0 forever and stall emulated time.
    function automatic logic [63:0] clamp_dur(input logic [63:0] x);
        return (x == 64'd0) ? 64'd1 : x;
    endfunction

endpackage

// File: rtl/dt_countdown.sv
// Remaining-time register for the current phase: load, compare against the grant, subtract.
module dt_countdown #(
    parameter int DT_WIDTH = 32
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                load_i,
    input  logic [DT_WIDTH-1:0] load_val_i,
    input  logic                dec_i,
    input  logic [DT_WIDTH-1:0] dt_i,
    output logic [DT_WIDTH-1:0] rem_o,
    output logic                done_o,
    output logic                over_o
);

    logic [DT_WIDTH-1:0] rem;

    assign rem_o  = rem;
    assign done_o = (dt_i >= rem);
    assign over_o = (dt_i > rem);

    // Subtraction only happens when the grant is strictly smaller, so it never wraps.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rem <= '0;
        end else if (load_i) begin
            rem <= load_val_i;
        end else if (dec_i && !done_o) begin
            rem <= rem - dt_i;
        end
    end

endmodule

// File: rtl/emu_clk_osc.sv
// Emulated-clock oscillator: requests time to next edge, consumes grants, toggles on exhaustion.
module emu_clk_osc
    import emu_osc_pkg::*;
#(
    parameter int DT_WIDTH  = DT_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [DT_WIDTH-1:0]  t_lo_i,
    input  logic [DT_WIDTH-1:0]  t_hi_i,
    input  logic                 step_i,
    input  logic [DT_WIDTH-1:0]  dt_i,
    output logic [DT_WIDTH-1:0]  dt_req_o,
    output logic                 clk_val_o,
    output logic                 rise_o,
    output logic                 fall_o,
    output logic [CNT_WIDTH-1:0] edge_cnt_o,
    output logic                 overrun_o
);

    osc_state_e          state;
    logic [DT_WIDTH-1:0] lo_dur, hi_dur, load_val, rem;
    logic                active, load, done, over, phase_end;

    assign lo_dur    = DT_WIDTH'(clamp_dur(64'(t_lo_i)));
    assign hi_dur    = DT_WIDTH'(clamp_dur(64'(t_hi_i)));
    assign active    = (state != ST_IDLE);
    assign phase_end = active && step_i && done;
    assign load      = (state == ST_IDLE) || phase_end;
    assign load_val  = (state == ST_LOW) ? hi_dur : lo_dur;
    assign dt_req_o  = rem;

    dt_countdown #(.DT_WIDTH(DT_WIDTH)) u_countdown (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (load),
        .load_val_i (load_val),
        .dec_i      (active && step_i),
        .dt_i       (dt_i),
        .rem_o      (rem),
        .done_o     (done),
        .over_o     (over)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= ST_IDLE;
            clk_val_o  <= 1'b0;
            rise_o     <= 1'b0;
            fall_o     <= 1'b0;
            edge_cnt_o <= '0;
            overrun_o  <= 1'b0;
        end else begin
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state     <= ST_LOW;
                    clk_val_o <= 1'b0;
                end
                ST_LOW: begin
                    if (phase_end) begin
                        state      <= ST_HIGH;
                        clk_val_o  <= 1'b1;
                        rise_o     <= 1'b1;
                        edge_cnt_o <= edge_cnt_o + CNT_WIDTH'(1);
                        overrun_o  <= overrun_o | over;
                    end
                end
                ST_HIGH: begin
                    if (phase_end) begin
                        state     <= ST_LOW;
                        clk_val_o <= 1'b0;
                        fall_o    <= 1'b1;
                        overrun_o <= overrun_o | over;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_emu_clk_osc.sv
// Self-checking bench for emu_clk_osc against a step-level behavioural model.
module tb_emu_clk_osc;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic [DW-1:0] t_lo_i = 32'd123;
    logic [DW-1:0] t_hi_i = 32'd234;
    logic          step_i = 1'b0;
    logic [DW-1:0] dt_i = '0;
    logic [DW-1:0] dt_req_o;
    logic          clk_val_o, rise_o, fall_o, overrun_o;
    logic [CW-1:0] edge_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: emulated time bookkeeping at the granularity of whole steps.
    bit          m_idle = 1'b1;
    bit          m_lvl, m_rise, m_fall, m_ovr;
    int unsigned m_rem, m_cnt;

    emu_clk_osc #(.DT_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .t_lo_i     (t_lo_i),
        .t_hi_i     (t_hi_i),
        .step_i     (step_i),
        .dt_i       (dt_i),
        .dt_req_o   (dt_req_o),
        .clk_val_o  (clk_val_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .edge_cnt_o (edge_cnt_o),
        .overrun_o  (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int unsigned dur(input logic [DW-1:0] x);
        return (x == 0) ? 1 : int'(x);
    endfunction

    task automatic model_reset();
        m_idle = 1'b1; m_lvl = 0; m_rise = 0; m_fall = 0; m_ovr = 0; m_rem = 0; m_cnt = 0;
    endtask

    // Apply one emulator cycle to DUT and model; sample 1 ns after the edge.
    task automatic tick(input bit st, input int unsigned dt);
        step_i = st;
        dt_i   = dt;
        @(posedge clk_i);
        #1;
        m_rise = 0;
        m_fall = 0;
        if (m_idle) begin
            m_idle = 0;
            m_lvl  = 0;
            m_rem  = dur(t_lo_i);
        end else if (st && dt >= m_rem) begin
            if (dt > m_rem) m_ovr = 1;
            m_lvl = !m_lvl;
            if (m_lvl) begin
                m_rise = 1;
                m_cnt  = (m_cnt + 1) % (1 << CW);
                m_rem  = dur(t_hi_i);
            end else begin
                m_fall = 1;
                m_rem  = dur(t_lo_i);
            end
        end else if (st) begin
            m_rem = m_rem - dt;
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst_n_i = 1'b0;
        #3;
        n_checks++;
        if (dt_req_o !== 0 || clk_val_o !== 0 || rise_o !== 0 || fall_o !== 0 ||
            edge_cnt_o !== 0 || overrun_o !== 0) begin
            n_fail++;
            $display("FAIL reset_vals: req=%0d clk=%b r=%b f=%b cnt=%0d ovr=%b, want all 0",
                     dt_req_o, clk_val_o, rise_o, fall_o, edge_cnt_o, overrun_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        n_checks++;
        if (dt_req_o !== 0) begin
            n_fail++; $display("FAIL idle_req: got %0d want 0", dt_req_o);
        end
        // step in IDLE must be ignored
        tick(1'b1, 5);
        n_checks++;
        if (dt_req_o !== 123 || clk_val_o !== 0 || rise_o !== 0) begin
            n_fail++;
            $display("FAIL first_req: req=%0d clk=%b rise=%b want 123/0/0", dt_req_o, clk_val_o, rise_o);
        end
    endtask

    task automatic test_full_grants();
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, m_rem);
            n_checks++;
            if (dt_req_o !== m_rem || clk_val_o !== m_lvl || rise_o !== m_rise ||
                fall_o !== m_fall || edge_cnt_o !== m_cnt[CW-1:0]) begin
                n_fail++;
                $display("FAIL full_grant[%0d]: req=%0d clk=%b r=%b f=%b cnt=%0d want %0d/%b/%b/%b/%0d",
                         i, dt_req_o, clk_val_o, rise_o, fall_o, edge_cnt_o,
                         m_rem, m_lvl, m_rise, m_fall, m_cnt);
            end
        end
        n_checks++;
        if (edge_cnt_o !== 4'd4 || dt_req_o !== 123) begin
            n_fail++; $display("FAIL full_summary: cnt=%0d req=%0d want 4/123", edge_cnt_o, dt_req_o);
        end
    endtask

    task automatic test_partial();
        int unsigned grants [3] = '{50, 50, 23};
        int unsigned reqs   [3] = '{123, 73, 23};
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (dt_req_o !== reqs[i]) begin
                n_fail++; $display("FAIL partial_req[%0d]: got %0d want %0d", i, dt_req_o, reqs[i]);
            end
            tick(1'b1, grants[i]);
            n_checks++;
            if (rise_o !== (i == 2) || clk_val_o !== (i == 2)) begin
                n_fail++;
                $display("FAIL partial_edge[%0d]: rise=%b clk=%b want %b", i, rise_o, clk_val_o, i == 2);
            end
        end
        n_checks++;
        if (dt_req_o !== 234 || edge_cnt_o !== 4'd5) begin
            n_fail++; $display("FAIL partial_high_req: req=%0d cnt=%0d want 234/5", dt_req_o, edge_cnt_o);
        end
    endtask

    task automatic test_overrun();
        tick(1'b1, 300);
        n_checks++;
        if (fall_o !== 1 || clk_val_o !== 0 || overrun_o !== 1 || dt_req_o !== 123) begin
            n_fail++;
            $display("FAIL overrun: f=%b clk=%b ovr=%b req=%0d want 1/0/1/123",
                     fall_o, clk_val_o, overrun_o, dt_req_o);
        end
        tick(1'b0, 0);
        tick(1'b1, 10);
        n_checks++;
        if (overrun_o !== 1 || fall_o !== 0 || dt_req_o !== 113) begin
            n_fail++;
            $display("FAIL overrun_sticky: ovr=%b f=%b req=%0d want 1/0/113", overrun_o, fall_o, dt_req_o);
        end
        tick(1'b1, 113);
        tick(1'b1, 234);
    endtask

    task automatic test_zero_dur();
        t_hi_i = 0;
        tick(1'b1, 123);
        n_checks++;
        if (rise_o !== 1 || dt_req_o !== 1) begin
            n_fail++; $display("FAIL zero_hi_req: rise=%b req=%0d want 1/1", rise_o, dt_req_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 0);
            n_checks++;
            if (clk_val_o !== 1 || rise_o !== 0 || fall_o !== 0 || dt_req_o !== 1) begin
                n_fail++;
                $display("FAIL zero_dt[%0d]: clk=%b r=%b f=%b req=%0d want 1/0/0/1",
                         i, clk_val_o, rise_o, fall_o, dt_req_o);
            end
        end
        tick(1'b1, 1);
        n_checks++;
        if (fall_o !== 1 || clk_val_o !== 0 || dt_req_o !== 123) begin
            n_fail++; $display("FAIL zero_hi_end: f=%b clk=%b req=%0d want 1/0/123", fall_o, clk_val_o, dt_req_o);
        end
        t_hi_i = 234;
    endtask

    task automatic test_mid_change();
        tick(1'b1, 50);
        t_lo_i = 500;
        tick(1'b0, 0);
        n_checks++;
        if (dt_req_o !== 73) begin
            n_fail++; $display("FAIL mid_change_rem: got %0d want 73", dt_req_o);
        end
        tick(1'b1, 73);
        n_checks++;
        if (rise_o !== 1 || dt_req_o !== 234) begin
            n_fail++; $display("FAIL mid_change_rise: rise=%b req=%0d want 1/234", rise_o, dt_req_o);
        end
        tick(1'b1, 234);
        n_checks++;
        if (fall_o !== 1 || dt_req_o !== 500) begin
            n_fail++; $display("FAIL mid_change_lo: f=%b req=%0d want 1/500", fall_o, dt_req_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            int unsigned dt;
            bit          st;
            int unsigned sel;
            if ($urandom_range(0, 9) == 0) t_lo_i = $urandom_range(0, 20);
            if ($urandom_range(0, 9) == 0) t_hi_i = $urandom_range(0, 20);
            st  = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 5);
            case (sel)
                0:       dt = 0;
                1, 2:    dt = m_rem;
                3:       dt = m_rem + $urandom_range(1, 100);
                default: dt = (m_rem > 1) ? $urandom_range(1, m_rem - 1) : m_rem;
            endcase
            tick(st, dt);
            n_checks++;
            if (dt_req_o !== m_rem || clk_val_o !== m_lvl || rise_o !== m_rise || fall_o !== m_fall ||
                edge_cnt_o !== m_cnt[CW-1:0] || overrun_o !== m_ovr) begin
                n_fail++;
                $display("FAIL random[%0d]: req=%0d clk=%b r=%b f=%b cnt=%0d ovr=%b want %0d/%b/%b/%b/%0d/%b",
                         i, dt_req_o, clk_val_o, rise_o, fall_o, edge_cnt_o, overrun_o,
                         m_rem, m_lvl, m_rise, m_fall, m_cnt, m_ovr);
            end
        end
    endtask

    task automatic test_async_reset_and_wrap();
        t_lo_i = 123;
        t_hi_i = 234;
        // drive into HIGH with a partial grant pending
        for (int i = 0; i < 4 && !(m_lvl && m_rem > 1); i++) tick(1'b1, m_rem);
        if (!m_lvl) tick(1'b1, m_rem);
        tick(1'b1, 1);
        rst_n_i = 1'b0;
        #1;
        n_checks++;
        if (clk_val_o !== 0 || dt_req_o !== 0 || edge_cnt_o !== 0 || overrun_o !== 0 ||
            rise_o !== 0 || fall_o !== 0) begin
            n_fail++;
            $display("FAIL async_reset: clk=%b req=%0d cnt=%0d ovr=%b r=%b f=%b want all 0",
                     clk_val_o, dt_req_o, edge_cnt_o, overrun_o, rise_o, fall_o);
        end
        model_reset();
        #2;
        rst_n_i = 1'b1;
        t_lo_i = 1;
        t_hi_i = 1;
        tick(1'b0, 0);
        n_checks++;
        if (dt_req_o !== 1) begin
            n_fail++; $display("FAIL post_reset_req: got %0d want 1", dt_req_o);
        end
        for (int i = 0; i < 32; i++) begin
            tick(1'b1, 1);
            n_checks++;
            if (edge_cnt_o !== m_cnt[CW-1:0] || clk_val_o !== m_lvl) begin
                n_fail++;
                $display("FAIL wrap_step[%0d]: cnt=%0d clk=%b want %0d/%b", i, edge_cnt_o, clk_val_o, m_cnt, m_lvl);
            end
        end
        n_checks++;
        if (edge_cnt_o !== 0 || clk_val_o !== 0) begin
            n_fail++; $display("FAIL wrap_16: cnt=%0d clk=%b want 0/0", edge_cnt_o, clk_val_o);
        end
    endtask

    initial begin
        test_reset();
        test_full_grants();
        test_partial();
        test_overrun();
        test_zero_dur();
        test_mid_change();
        test_random();
        test_async_reset_and_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
